ext_bus_ctrl: RTL and testbench

EXT_BUS_CTRL -- requirements
Module: ext_bus_ctrl

---
 rtl/ext_bus_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ext_bus_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_ctrl.sv
// -----------------------------------------------------------------------------
// ext_bus_ctrl
//
// Bridges the CPU main bus to a shared 8-bit GPIO pad bus. Two external
// devices (13 and 14) are served:
//   * load strobes: the FPGA drives the pads and pulses devN_load_pin.
//   * assert strobes: the FPGA releases the pads, waits a turnaround gap,
//     pulls devN_assert_pin low, and captures the synchronised pad value
//     into main_in until the CPU drops the request.
//
// The bus direction only changes through an idle gap with pad_oe low. The
// pad enable and the assert strobes come from mutually exclusive states
// and are both registered, so they can never overlap, not even on an edge.
//
// Parameters
//   TURNAROUND  : idle cycles with pad_oe low between direction changes (1..15)
//   SYNC_STAGES : depth of the pad_in synchroniser (2..3)
//
// Ports
//   clk                : single clock, all flops on the rising edge
//   reset              : asynchronous active-low reset
//   devN_load_main     : active-low load request from CPU decode
//   devN_assert_main   : active-low assert (read) request from CPU decode
//   main_out[7:0]      : CPU main-bus value to present on the pads
//   pad_in[7:0]        : raw asynchronous pad value
//   pad_out[7:0]       : registered pad drive value
//   pad_oe             : pad output enable, high = FPGA drives the pads
//   devN_load_pin      : registered active-low load strobe
//   devN_assert_pin    : registered active-low assert strobe
//   main_in[7:0]       : captured external data for the CPU
//   main_in_valid      : main_in holds synchronised external data
//   conflict           : sticky protocol-violation flag
//   conflict_cnt[7:0]  : saturating count of violation events
// -----------------------------------------------------------------------------
module ext_bus_ctrl #(
  parameter int unsigned TURNAROUND  = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dev13_load_main,
  input  logic       dev13_assert_main,
  input  logic       dev14_load_main,
  input  logic       dev14_assert_main,
  input  logic [7:0] main_out,
  input  logic [7:0] pad_in,
  output logic [7:0] pad_out,
  output logic       pad_oe,
  output logic       dev13_load_pin,
  output logic       dev13_assert_pin,
  output logic       dev14_load_pin,
  output logic       dev14_assert_pin,
  output logic [7:0] main_in,
  output logic       main_in_valid,
  output logic       conflict,
  output logic [7:0] conflict_cnt
);

  typedef enum logic [1:0] {
    S_DRIVE    = 2'd0,
    S_TURN_OUT = 2'd1,
    S_EXT_READ = 2'd2,
    S_TURN_IN  = 2'd3
  } state_e;

  // Last value of the gap counter before the gap ends.
  localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);
  // Read-cycle count at which the synchroniser pipe holds post-grant data;
  // valid rises on the SYNC_STAGES-th cycle spent in EXT_READ.
  localparam logic [1:0] RD_THRESH = 2'(SYNC_STAGES - 2);

  // ---------------------------------------------------------------------------
  // Request decode (internal signals are active high)
  // ---------------------------------------------------------------------------
  logic ld13, ld14, as13, as14;
  assign ld13 = ~dev13_load_main;
  assign ld14 = ~dev14_load_main;
  assign as13 = ~dev13_assert_main;
  assign as14 = ~dev14_assert_main;

  // ---------------------------------------------------------------------------
  // pad_in synchroniser: index 0 takes the raw pad, index SYNC_STAGES-1 is
  // the only stage the rest of the design may look at.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  pad_sync;

  // NOTE: these are a handful of flops, not a RAM, so they take the reset;
  // that keeps main_in deterministic when the first read follows reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignment lets each stage take the old value of
      // its neighbour, which is what makes this a shift chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
    end
  end

  assign pad_sync = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       grant14_q, grant14_d;   // 0: dev13 owns the read, 1: dev14

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_TURN_IN;
      gap_cnt_q <= '0;
      grant14_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      grant14_q <= grant14_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  logic granted_req;
  assign granted_req = grant14_q ? as14 : as13;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    grant14_d = grant14_q;

    unique case (state_q)
      S_DRIVE: begin
        if (as13 || as14) begin
          state_d   = S_TURN_OUT;
          gap_cnt_d = '0;
          // Grant is fixed here; dev13 wins a simultaneous request.
          grant14_d = ~as13;
        end
      end
      S_TURN_OUT: begin
        if (gap_cnt_q == TURN_LAST) begin
          state_d = S_EXT_READ;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      S_EXT_READ: begin
        // Only the granted request matters here; the other one waits until
        // the bus is back in DRIVE.
        if (!granted_req) begin
          state_d   = S_TURN_IN;
          gap_cnt_d = '0;
        end
      end
      S_TURN_IN: begin
        if (gap_cnt_q == TURN_LAST) begin
          state_d = S_DRIVE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = S_TURN_IN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  logic [7:0] pad_out_q, pad_out_d;
  logic       pad_oe_q, pad_oe_d;
  logic       ld13_pin_q, ld13_pin_d;
  logic       ld14_pin_q, ld14_pin_d;
  logic       as13_pin_q, as13_pin_d;
  logic       as14_pin_q, as14_pin_d;
  logic [7:0] main_in_q, main_in_d;
  logic       valid_q, valid_d;
  logic [1:0] rd_cnt_q, rd_cnt_d;
  logic       conflict_q, conflict_d;
  logic [7:0] conf_cnt_q, conf_cnt_d;

  logic stay_drive;
  logic stay_read;
  logic conf_event;

  always_comb begin
    stay_drive = (state_q == S_DRIVE)    && (state_d == S_DRIVE);
    stay_read  = (state_q == S_EXT_READ) && (state_d == S_EXT_READ);

    // Derived from the next state so the enable and the assert strobes
    // switch on the same edge as the state, never from overlapping states.
    pad_oe_d   = (state_d == S_DRIVE);
    as13_pin_d = ~((state_d == S_EXT_READ) && !grant14_d);
    as14_pin_d = ~((state_d == S_EXT_READ) &&  grant14_d);

    // Loads only pass while the bus stays driven; any assert request leaves
    // DRIVE, so a load paired with an assert is dropped automatically.
    ld13_pin_d = ~(stay_drive && ld13);
    ld14_pin_d = ~(stay_drive && ld14);

    // Track main_out while driving, and load it again on entry to DRIVE.
    pad_out_d  = ((state_q == S_DRIVE) || (state_d == S_DRIVE)) ? main_out : pad_out_q;

    // Capture while the granted request is still held; hold on exit.
    main_in_d  = stay_read ? pad_sync : main_in_q;
    rd_cnt_d   = '0;
    if (stay_read) begin
      rd_cnt_d = (rd_cnt_q == 2'd3) ? rd_cnt_q : rd_cnt_q + 2'd1;
    end
    valid_d    = stay_read && (valid_q || (rd_cnt_q == RD_THRESH));

    // Several violations in one cycle are one event.
    if (state_q == S_DRIVE) begin
      conf_event = (ld13 && as13) || (ld14 && as14) || (as13 && as14);
    end else begin
      conf_event = ld13 || ld14;
    end
    conflict_d = conflict_q | conf_event;
    conf_cnt_d = (conf_event && (conf_cnt_q != 8'hFF)) ? conf_cnt_q + 8'd1 : conf_cnt_q;
  end

  // ---------------------------------------------------------------------------
  // Output registers. Reset puts every strobe high and the pads released
  // immediately, without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pad_out_q  <= '0;
      pad_oe_q   <= 1'b0;
      ld13_pin_q <= 1'b1;
      ld14_pin_q <= 1'b1;
      as13_pin_q <= 1'b1;
      as14_pin_q <= 1'b1;
      main_in_q  <= '0;
      valid_q    <= 1'b0;
      rd_cnt_q   <= '0;
      conflict_q <= 1'b0;
      conf_cnt_q <= '0;
    end else begin
      pad_out_q  <= pad_out_d;
      pad_oe_q   <= pad_oe_d;
      ld13_pin_q <= ld13_pin_d;
      ld14_pin_q <= ld14_pin_d;
      as13_pin_q <= as13_pin_d;
      as14_pin_q <= as14_pin_d;
      main_in_q  <= main_in_d;
      valid_q    <= valid_d;
      rd_cnt_q   <= rd_cnt_d;
      conflict_q <= conflict_d;
      conf_cnt_q <= conf_cnt_d;
    end
  end

  assign pad_out          = pad_out_q;
  assign pad_oe           = pad_oe_q;
  assign dev13_load_pin   = ld13_pin_q;
  assign dev14_load_pin   = ld14_pin_q;
  assign dev13_assert_pin = as13_pin_q;
  assign dev14_assert_pin = as14_pin_q;
  assign main_in          = main_in_q;
  assign main_in_valid    = valid_q;
  assign conflict         = conflict_q;
  assign conflict_cnt     = conf_cnt_q;

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ext_bus_ctrl
//
// Directed stimulus with hand-computed expectations, plus a behavioural
// model of the bus protocol that every output is compared against on each
// falling clock edge. Inputs change 2 ns after a rising edge; literal checks
// are taken at the same point, after the outputs have settled.
// -----------------------------------------------------------------------------
module tb_ext_bus_ctrl;

  localparam int T = 1;   // TURNAROUND
  localparam int S = 2;   // SYNC_STAGES

  logic       clk = 1'b0;
  logic       reset;
  logic       dev13_load_main, dev13_assert_main, dev14_load_main, dev14_assert_main;
  logic [7:0] main_out, pad_in;
  logic [7:0] pad_out;
  logic       pad_oe;
  logic       dev13_load_pin, dev13_assert_pin, dev14_load_pin, dev14_assert_pin;
  logic [7:0] main_in;
  logic       main_in_valid, conflict;
  logic [7:0] conflict_cnt;

  always #5 clk = ~clk;

  ext_bus_ctrl #(.TURNAROUND(T), .SYNC_STAGES(S)) dut (
    .clk              (clk),
    .reset            (reset),
    .dev13_load_main  (dev13_load_main),
    .dev13_assert_main(dev13_assert_main),
    .dev14_load_main  (dev14_load_main),
    .dev14_assert_main(dev14_assert_main),
    .main_out         (main_out),
    .pad_in           (pad_in),
    .pad_out          (pad_out),
    .pad_oe           (pad_oe),
    .dev13_load_pin   (dev13_load_pin),
    .dev13_assert_pin (dev13_assert_pin),
    .dev14_load_pin   (dev14_load_pin),
    .dev14_assert_pin (dev14_assert_pin),
    .main_in          (main_in),
    .main_in_valid    (main_in_valid),
    .conflict         (conflict),
    .conflict_cnt     (conflict_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: bus mode plus a countdown of remaining quiet cycles.
  // ---------------------------------------------------------------------------
  localparam int M_DRIVE = 0, M_QUIET_OUT = 1, M_READ = 2, M_QUIET_IN = 3;

  int         m_mode, m_left, m_dev, m_reads, m_cnt;
  logic [7:0] m_pad_out, m_main_in;
  bit         m_valid, m_conf, m_lp13, m_lp14, m_ap13, m_ap14;
  logic [7:0] m_hist[$];

  always @(posedge clk or negedge reset) begin : model
    bit         l13, l14, r13, r14, ev, held;
    logic [7:0] synced;
    if (!reset) begin
      m_mode = M_QUIET_IN; m_left = T; m_dev = 13; m_reads = 0; m_cnt = 0;
      m_pad_out = 8'h00; m_main_in = 8'h00; m_valid = 0; m_conf = 0;
      m_lp13 = 1; m_lp14 = 1; m_ap13 = 1; m_ap14 = 1;
      m_hist = {};
      repeat (S) m_hist.push_back(8'h00);
    end else begin
      l13 = !dev13_load_main;   l14 = !dev14_load_main;
      r13 = !dev13_assert_main; r14 = !dev14_assert_main;
      if (m_mode == M_DRIVE) ev = (l13 && r13) || (l14 && r14) || (r13 && r14);
      else                   ev = l13 || l14;
      if (ev) begin
        m_conf = 1;
        if (m_cnt < 255) m_cnt++;
      end
      // Value that has crossed S flops: pad_in as sampled S edges ago.
      synced = m_hist.pop_front();
      m_hist.push_back(pad_in);
      case (m_mode)
        M_DRIVE: begin
          m_pad_out = main_out;
          if (r13 || r14) begin
            m_dev = r13 ? 13 : 14;
            m_mode = M_QUIET_OUT; m_left = T;
            m_lp13 = 1; m_lp14 = 1;
          end else begin
            m_lp13 = !l13; m_lp14 = !l14;
          end
        end
        M_QUIET_OUT: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_READ; m_reads = 1;
            if (m_dev == 13) m_ap13 = 0; else m_ap14 = 0;
          end
        end
        M_READ: begin
          held = (m_dev == 13) ? r13 : r14;
          if (held) begin
            m_reads++;
            m_main_in = synced;
            m_valid = (m_reads >= S);
          end else begin
            m_mode = M_QUIET_IN; m_left = T;
            m_ap13 = 1; m_ap14 = 1; m_valid = 0;
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_DRIVE;
            m_pad_out = main_out;
          end
        end
      endcase
    end
  end

  // One compare process, every cycle.
  always @(negedge clk) begin
    check("pad_oe",        pad_oe,           m_mode == M_DRIVE);
    check("pad_out",       pad_out,          m_pad_out);
    check("dev13_load",    dev13_load_pin,   m_lp13);
    check("dev14_load",    dev14_load_pin,   m_lp14);
    check("dev13_assert",  dev13_assert_pin, m_ap13);
    check("dev14_assert",  dev14_assert_pin, m_ap14);
    check("main_in",       main_in,          m_main_in);
    check("main_in_valid", main_in_valid,    m_valid);
    check("conflict",      conflict,         m_conf);
    check("conflict_cnt",  conflict_cnt,     m_cnt);
    check("oe_vs_assert",  pad_oe & (~dev13_assert_pin | ~dev14_assert_pin), 1'b0);
  end

  // Same interlock, sampled just after each rising edge as well.
  always @(posedge clk) begin
    #1 check("oe_vs_assert_edge", pad_oe & (~dev13_assert_pin | ~dev14_assert_pin), 1'b0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    dev13_load_main = 1; dev13_assert_main = 1;
    dev14_load_main = 1; dev14_assert_main = 1;
    main_out = 8'h00; pad_in = 8'h00;
    reset = 1;
    #1 reset = 0;
    step(2);
    check("rst_pad_oe",   pad_oe, 0);
    check("rst_pins",     {dev13_load_pin, dev13_assert_pin, dev14_load_pin, dev14_assert_pin}, 4'hF);
    check("rst_pad_out",  pad_out, 8'h00);
    check("rst_cnt",      conflict_cnt, 8'h00);
    check("rst_valid",    main_in_valid, 0);

    // Release just after edge 1; DRIVE from edge 2.
    main_out = 8'hA5;
    @(posedge clk);
    #1 reset = 1;
    #1 check("rel_e1_pad_oe", pad_oe, 0);
    step(1);
    check("rel_e2_pad_oe",  pad_oe, 1);
    check("rel_e2_pad_out", pad_out, 8'hA5);
    check("rel_e2_pins",    {dev13_load_pin, dev13_assert_pin, dev14_load_pin, dev14_assert_pin}, 4'hF);

    // One-cycle dev14 load.
    main_out = 8'h3C; dev14_load_main = 0;
    step(1);
    check("ld14_pin_low", dev14_load_pin, 0);
    check("ld14_pad_out", pad_out, 8'h3C);
    check("ld14_pad_oe",  pad_oe, 1);
    check("ld14_other",   dev13_load_pin, 1);
    dev14_load_main = 1;
    step(1);
    check("ld14_pin_high", dev14_load_pin, 1);

    // dev13 read, 8 cycles.
    pad_in = 8'h5A;
    step(3);
    dev13_assert_main = 0;
    step(1);
    check("rd_e1_pad_oe", pad_oe, 0);
    check("rd_e1_pin",    dev13_assert_pin, 1);
    step(1);
    check("rd_e2_pin",    dev13_assert_pin, 0);
    check("rd_e2_valid",  main_in_valid, 0);
    step(1);
    check("rd_e3_main_in", main_in, 8'h5A);
    check("rd_e3_valid",   main_in_valid, 1);
    step(1);
    pad_in = 8'hC3;
    step(2);
    check("rd_e6_main_in", main_in, 8'h5A);
    step(1);
    check("rd_e7_main_in", main_in, 8'hC3);
    step(1);
    dev13_assert_main = 1;
    step(1);
    check("rd_e9_pin",     dev13_assert_pin, 1);
    check("rd_e9_valid",   main_in_valid, 0);
    check("rd_e9_main_in", main_in, 8'hC3);
    check("rd_e9_pad_oe",  pad_oe, 0);
    step(1);
    check("rd_e10_pad_oe", pad_oe, 1);
    check("rd_no_conflict", conflict, 0);

    // Simultaneous asserts: dev13 granted, dev14 served afterwards.
    dev13_assert_main = 0; dev14_assert_main = 0;
    step(1);
    check("both_conflict", conflict, 1);
    check("both_cnt",      conflict_cnt, 8'd1);
    step(1);
    check("both_pin13", dev13_assert_pin, 0);
    check("both_pin14", dev14_assert_pin, 1);
    step(2);
    dev13_assert_main = 1;
    step(2);
    check("both_back_drive", pad_oe, 1);
    step(2);
    check("both_pin14_served", dev14_assert_pin, 0);
    check("both_cnt_still",    conflict_cnt, 8'd1);
    dev14_assert_main = 1;
    step(3);

    // Loads during a read: 300 violations, counter saturates.
    dev13_assert_main = 0;
    step(2);
    dev13_load_main = 0;
    step(10);
    check("sat_cnt_11", conflict_cnt, 8'd11);
    check("sat_ld_pin", dev13_load_pin, 1);
    step(290);
    check("sat_cnt_255",  conflict_cnt, 8'd255);
    check("sat_conflict", conflict, 1);
    check("sat_ld_pin2",  dev13_load_pin, 1);
    check("sat_as_pin",   dev13_assert_pin, 0);
    dev13_load_main = 1; dev13_assert_main = 1;
    step(2);
    check("sat_drive", pad_oe, 1);
    check("sat_hold",  conflict_cnt, 8'd255);

    // Reset in the middle of a read releases the strobe before the next edge.
    dev13_assert_main = 0;
    step(3);
    check("mid_rst_pre", dev13_assert_pin, 0);
    #1 reset = 0;
    #1;
    check("mid_rst_pin",    dev13_assert_pin, 1);
    check("mid_rst_pad_oe", pad_oe, 0);
    check("mid_rst_cnt",    conflict_cnt, 8'd0);
    check("mid_rst_main",   main_in, 8'h00);
    dev13_assert_main = 1;
    step(1);
    reset = 1;
    step(1);
    check("mid_rst_drive", pad_oe, 1);

    // Same-device load and assert in DRIVE: assert wins, one event.
    dev14_load_main = 0; dev14_assert_main = 0;
    step(1);
    check("same_cnt",    conflict_cnt, 8'd1);
    check("same_ld_pin", dev14_load_pin, 1);
    dev14_load_main = 1;
    step(1);
    check("same_as_pin", dev14_assert_pin, 0);
    dev14_assert_main = 1;
    step(3);

    // Load of one device with assert of the other is not a violation.
    dev13_load_main = 0; dev14_assert_main = 0;
    step(1);
    check("cross_cnt",    conflict_cnt, 8'd1);
    check("cross_ld_pin", dev13_load_pin, 1);
    dev13_load_main = 1;
    step(1);
    dev14_assert_main = 1;
    step(4);
    check("end_drive", pad_oe, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
